// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - double-buffered 3-channel RGB PWM driver with valid/ready duty input
module rgb_pwm_driver #(
   parameter int unsigned CLK_FREQUENCY = 12000000,
   parameter int unsigned PRESCALE      = 4,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       duty_valid,
   output logic       duty_ready,
   input  logic [7:0] duty_r,
   input  logic [7:0] duty_g,
   input  logic [7:0] duty_b,
   output logic       period_start,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B
);

   // Last prescaler count; PRESCALE=1 makes this 0 so every clk is a tick.
   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
   // pwm_cnt runs 0..254 so a duty of 255 compares true on every count.
   localparam logic [7:0]  PWM_LAST = 8'd254;

   // Reject illegal prescale values (and a meaningless clock frequency) at elaboration.
   generate
      if (PRESCALE < 1 || PRESCALE > 65535 || CLK_FREQUENCY < 1) begin : g_bad_param
         $error("rgb_pwm_driver: PRESCALE must be 1..65535 and CLK_FREQUENCY nonzero");
      end
   endgenerate

   typedef enum logic {
      ST_EMPTY   = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [15:0] pre_cnt;
   logic [7:0]  pwm_cnt;
   logic        tick;
   logic        boundary;

   logic        accept;
   logic        apply;

   logic [7:0]  shadow_r;
   logic [7:0]  shadow_g;
   logic [7:0]  shadow_b;
   logic [7:0]  active_r;
   logic [7:0]  active_g;
   logic [7:0]  active_b;

   logic        on_r;
   logic        on_g;
   logic        on_b;

   assign tick     = (pre_cnt == PRE_LAST);
   assign boundary = tick && (pwm_cnt == PWM_LAST);

   // Prescaler: free-running 0..PRESCALE-1, tick on the last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= 16'd0;
      end else if (tick) begin
         pre_cnt <= 16'd0;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   // PWM counter: advances once per tick, wraps 254 -> 0 at the period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= 8'd0;
      end else if (boundary) begin
         pwm_cnt <= 8'd0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   // Handshake FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next state: EMPTY accepts a triplet (even on a boundary clk, where it must
   // wait for the following boundary); PENDING hands it over at the next boundary.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      apply      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (duty_valid) begin
               accept     = 1'b1;
               state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (boundary) begin
               apply      = 1'b1;
               state_next = ST_EMPTY;
            end
         end
         default: begin
            state_next = ST_EMPTY;
         end
      endcase
   end

   // Ready is the registered state itself, so it drops the clk after an accept.
   assign duty_ready = (state == ST_EMPTY);

   // Shadow buffer: captures all three channels together on an accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_r <= 8'd0;
         shadow_g <= 8'd0;
         shadow_b <= 8'd0;
      end else if (accept) begin
         shadow_r <= duty_r;
         shadow_g <= duty_g;
         shadow_b <= duty_b;
      end
   end

   // Active duties: loaded from the shadow only at a boundary, never mid-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r <= 8'd0;
         active_g <= 8'd0;
         active_b <= 8'd0;
      end else if (apply) begin
         active_r <= shadow_r;
         active_g <= shadow_g;
         active_b <= shadow_b;
      end
   end

   // Period marker: one-clk pulse following every wrap, whether or not duties changed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
      end
   end

   // Registered compare keeps the pins free of combinational glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         on_r <= 1'b0;
         on_g <= 1'b0;
         on_b <= 1'b0;
      end else begin
         on_r <= (pwm_cnt < active_r);
         on_g <= (pwm_cnt < active_g);
         on_b <= (pwm_cnt < active_b);
      end
   end

   assign RGB_R = on_r ^ ACTIVE_LOW;
   assign RGB_G = on_g ^ ACTIVE_LOW;
   assign RGB_B = on_b ^ ACTIVE_LOW;

endmodule
